ex_fp_scheduler: RTL and testbench

Sequencing controller for the execute stage's integer ALU and floating-point ALU. Gives FP ops a fixed multi-cycle latency per operation class and stalls the pipeline front end while an FP op is in flight. Captures the completing result into a single writeback register. Keeps sticky FP exception status.

---
 rtl/ex_fp_scheduler_if.sv | 40 ++++
 rtl/ex_fp_scheduler.sv | 165 ++++++++++++++++
 tb/tb_ex_fp_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_fp_scheduler_if.sv
// Issue / writeback bundle between the EX stage and ex_fp_scheduler.
// master = pipeline side (drives issue operands), slave = scheduler.
interface ex_fp_scheduler_if;
  logic        issue_valid;
  logic        issue_is_nop;
  logic        issue_is_fp;
  logic [4:0]  issue_alu_op;
  logic [4:0]  issue_rd_num;
  logic        issue_reg_write;
  logic        flush;
  logic [31:0] alu_result;
  logic [31:0] falu_result;
  logic [5:0]  fp_flags;
  logic        fp_status_clear;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd_num;
  logic        wb_reg_write;
  logic        wb_is_fp;
  logic [5:0]  wb_fp_flags;
  logic [5:0]  fp_status;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_fp_ops;

  modport master (
    output issue_valid, issue_is_nop, issue_is_fp, issue_alu_op, issue_rd_num,
           issue_reg_write, flush, alu_result, falu_result, fp_flags, fp_status_clear,
    input  stall, busy, wb_valid, wb_result, wb_rd_num, wb_reg_write, wb_is_fp,
           wb_fp_flags, fp_status, perf_stall_cycles, perf_fp_ops
  );

  modport slave (
    input  issue_valid, issue_is_nop, issue_is_fp, issue_alu_op, issue_rd_num,
           issue_reg_write, flush, alu_result, falu_result, fp_flags, fp_status_clear,
    output stall, busy, wb_valid, wb_result, wb_rd_num, wb_reg_write, wb_is_fp,
           wb_fp_flags, fp_status, perf_stall_cycles, perf_fp_ops
  );
endinterface

// File: rtl/ex_fp_scheduler.sv
// Execute-stage sequencer: fixed-latency FP ops with front-end stall, one writeback register, sticky FP status.
// Define EX_SCHED_PERF_CNT_EN to build the perf counters; otherwise the perf outputs are tied to 0.
//
// state | meaning
// IDLE  | accepting ops; integer and single-cycle FP ops complete from here
// BUSY  | multi-cycle FP op in flight; r_count==0 marks its completion cycle
module ex_fp_scheduler #(
  parameter int LAT_FADD = 3,
  parameter int LAT_FMUL = 4,
  parameter int LAT_FDIV = 12,
  parameter int CNT_W    = 4
) (
  input logic              clk,
  input logic              reset,
  ex_fp_scheduler_if.slave bus
);
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [15:0]      w_lat;
  logic             w_accept, w_fp_single, w_start_multi;
  logic             w_cap_int, w_cap_fp_single, w_cap_fp_multi, w_fp_done;
  logic             w_stall, w_busy;
  logic             w_unused;

  logic             r_wb_valid, r_wb_reg_write, r_wb_is_fp;
  logic [31:0]      r_wb_result;
  logic [4:0]       r_wb_rd_num, r_pend_rd_num;
  logic             r_pend_reg_write;
  logic [5:0]       r_wb_fp_flags, r_fp_status;

  assign w_unused = ^bus.issue_alu_op[4:2];

  always_comb begin
    case (bus.issue_alu_op[1:0])
      2'b10:   w_lat = 16'(LAT_FMUL);
      2'b11:   w_lat = 16'(LAT_FDIV);
      default: w_lat = 16'(LAT_FADD);
    endcase
  end

  assign w_accept        = bus.issue_valid & ~bus.issue_is_nop & ~bus.flush & (r_state == S_IDLE);
  assign w_fp_single     = (w_lat == 16'd1);
  assign w_cap_int       = w_accept & ~bus.issue_is_fp;
  assign w_cap_fp_single = w_accept & bus.issue_is_fp & w_fp_single;
  assign w_start_multi   = w_accept & bus.issue_is_fp & ~w_fp_single;
  // flush outranks completion in the final BUSY cycle
  assign w_cap_fp_multi  = (r_state == S_BUSY) & (r_count == '0) & ~bus.flush;
  assign w_fp_done       = w_cap_fp_single | w_cap_fp_multi;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_stall     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_multi) begin
          w_stall     = 1'b1;
          w_state_nxt = S_BUSY;
          w_count_nxt = CNT_W'(w_lat - 16'd2);
        end
      end
      S_BUSY: begin
        w_busy = 1'b1;
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (r_count != '0) begin
          w_stall     = 1'b1;
          w_count_nxt = r_count - CNT_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid       <= 1'b0;
      r_wb_result      <= '0;
      r_wb_rd_num      <= '0;
      r_wb_reg_write   <= 1'b0;
      r_wb_is_fp       <= 1'b0;
      r_wb_fp_flags    <= '0;
      r_fp_status      <= '0;
      r_pend_rd_num    <= '0;
      r_pend_reg_write <= 1'b0;
    end else begin
      r_wb_valid <= w_cap_int | w_fp_done;
      if (w_start_multi) begin
        r_pend_rd_num    <= bus.issue_rd_num;
        r_pend_reg_write <= bus.issue_reg_write;
      end
      if (w_cap_int | w_cap_fp_single) begin
        r_wb_result    <= bus.issue_is_fp ? bus.falu_result : bus.alu_result;
        r_wb_rd_num    <= bus.issue_rd_num;
        r_wb_reg_write <= bus.issue_reg_write;
        r_wb_is_fp     <= bus.issue_is_fp;
        r_wb_fp_flags  <= bus.issue_is_fp ? bus.fp_flags : 6'd0;
      end else if (w_cap_fp_multi) begin
        r_wb_result    <= bus.falu_result;
        r_wb_rd_num    <= r_pend_rd_num;
        r_wb_reg_write <= r_pend_reg_write;
        r_wb_is_fp     <= 1'b1;
        r_wb_fp_flags  <= bus.fp_flags;
      end
      // a clear coinciding with completion keeps only the new flags
      if (w_fp_done)
        r_fp_status <= (bus.fp_status_clear ? 6'd0 : r_fp_status) | bus.fp_flags;
      else if (bus.fp_status_clear)
        r_fp_status <= '0;
    end
  end

  assign bus.stall        = w_stall & ~reset;
  assign bus.busy         = w_busy;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_result    = r_wb_result;
  assign bus.wb_rd_num    = r_wb_rd_num;
  assign bus.wb_reg_write = r_wb_reg_write;
  assign bus.wb_is_fp     = r_wb_is_fp;
  assign bus.wb_fp_flags  = r_wb_fp_flags;
  assign bus.fp_status    = r_fp_status;

`ifdef EX_SCHED_PERF_CNT_EN
  logic [31:0] r_perf_stall, r_perf_fp;
  logic [31:0] w_perf_stall_base, w_perf_fp_base;

  assign w_perf_stall_base = bus.fp_status_clear ? 32'd0 : r_perf_stall;
  assign w_perf_fp_base    = bus.fp_status_clear ? 32'd0 : r_perf_fp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_fp    <= '0;
    end else begin
      r_perf_stall <= (bus.stall && (w_perf_stall_base != '1)) ? w_perf_stall_base + 32'd1
                                                                : w_perf_stall_base;
      r_perf_fp    <= (w_fp_done && (w_perf_fp_base != '1)) ? w_perf_fp_base + 32'd1
                                                             : w_perf_fp_base;
    end
  end

  assign bus.perf_stall_cycles = r_perf_stall;
  assign bus.perf_fp_ops       = r_perf_fp;
`else
  assign bus.perf_stall_cycles = 32'd0;
  assign bus.perf_fp_ops       = 32'd0;
`endif

endmodule

// File: tb/tb_ex_fp_scheduler.sv
// Bench for ex_fp_scheduler: directed scenarios plus random traffic against an op-level reference model.
module tb_ex_fp_scheduler;
  localparam int LAT_FADD = 3;
  localparam int LAT_FMUL = 4;
  localparam int LAT_FDIV = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_fp_scheduler_if bus ();

  ex_fp_scheduler #(
    .LAT_FADD(LAT_FADD),
    .LAT_FMUL(LAT_FMUL),
    .LAT_FDIV(LAT_FDIV),
    .CNT_W   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // per-cycle stimulus
  logic        d_valid, d_nop, d_fp, d_rw, d_flush, d_clr;
  logic [4:0]  d_op, d_rd;
  logic [31:0] d_alu, d_falu;
  logic [5:0]  d_flags;

  // reference model: op-level view (cycle numbers, pending op record)
  int          cyc;
  logic        m_pend;
  int          m_fin;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        e_wb;
  logic [31:0] e_res;
  logic [4:0]  e_rd;
  logic        e_rw, e_isfp;
  logic [5:0]  e_flags, e_status;
  logic [31:0] e_perf_stall, e_perf_fp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [4:0] op);
    case (op[1:0])
      2'b10:   return LAT_FMUL;
      2'b11:   return LAT_FDIV;
      default: return LAT_FADD;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 1'b0; m_fin = 0; m_rd = '0; m_rw = 1'b0;
    e_wb = 1'b0; e_res = '0; e_rd = '0; e_rw = 1'b0; e_isfp = 1'b0;
    e_flags = '0; e_status = '0; e_perf_stall = '0; e_perf_fp = '0;
  endtask

  task automatic set_idle();
    d_valid = 0; d_nop = 0; d_fp = 0; d_rw = 0; d_flush = 0; d_clr = 0;
    d_op = '0; d_rd = '0; d_alu = '0; d_falu = '0; d_flags = '0;
  endtask

  task automatic set_op(input logic fp, input logic [4:0] op, input logic [4:0] rd,
                        input logic [31:0] res, input logic [5:0] flags);
    set_idle();
    d_valid = 1; d_fp = fp; d_op = op; d_rd = rd; d_rw = 1;
    if (fp) begin d_falu = res; d_flags = flags; d_alu = 32'hDEAD_BEEF; end
    else    begin d_alu = res; d_falu = 32'hBAD0_F00D; d_flags = 6'b111111; end
  endtask

  task automatic set_random();
    d_valid = ($urandom_range(0, 9) < 7);
    d_nop   = ($urandom_range(0, 9) == 0);
    d_fp    = ($urandom_range(0, 1) == 1);
    d_rw    = ($urandom_range(0, 1) == 1);
    d_flush = ($urandom_range(0, 19) == 0);
    d_clr   = ($urandom_range(0, 24) == 0);
    d_op    = 5'($urandom_range(0, 31));
    d_rd    = 5'($urandom_range(0, 31));
    d_alu   = $urandom;
    d_falu  = $urandom;
    d_flags = 6'($urandom_range(0, 63));
  endtask

  // one clock cycle: drive, check combinational outputs, then check registered results
  task automatic step();
    logic acc, comp, e_stall, e_busy;
    int   L;
    bus.issue_valid = d_valid;  bus.issue_is_nop = d_nop;   bus.issue_is_fp = d_fp;
    bus.issue_alu_op = d_op;    bus.issue_rd_num = d_rd;    bus.issue_reg_write = d_rw;
    bus.flush = d_flush;        bus.alu_result = d_alu;     bus.falu_result = d_falu;
    bus.fp_flags = d_flags;     bus.fp_status_clear = d_clr;
    #2;
    comp = 0; e_stall = 0; e_busy = 0; e_wb = 0;
    if (m_pend) begin
      e_busy  = 1;
      e_stall = (cyc < m_fin) && !d_flush;
      if (d_flush) m_pend = 0;
      else if (cyc == m_fin) begin
        comp = 1; m_pend = 0; e_rd = m_rd; e_rw = m_rw;
      end
    end else begin
      acc = d_valid && !d_nop && !d_flush;
      L   = lat_of(d_op);
      if (acc && !d_fp) begin
        e_wb = 1; e_res = d_alu; e_rd = d_rd; e_rw = d_rw; e_isfp = 0; e_flags = '0;
      end else if (acc && L == 1) begin
        comp = 1; e_rd = d_rd; e_rw = d_rw;
      end else if (acc) begin
        e_stall = 1; m_pend = 1; m_fin = cyc + L - 1; m_rd = d_rd; m_rw = d_rw;
      end
    end
    if (comp) begin
      e_wb = 1; e_res = d_falu; e_isfp = 1; e_flags = d_flags;
      e_status = (d_clr ? 6'd0 : e_status) | d_flags;
    end else if (d_clr) begin
      e_status = '0;
    end
    if (d_clr) begin e_perf_stall = '0; e_perf_fp = '0; end
    if (e_stall && e_perf_stall != '1) e_perf_stall++;
    if (comp && e_perf_fp != '1) e_perf_fp++;
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    @(posedge clk); #1;
    cyc++;
    chk("wb_valid", 32'(bus.wb_valid), 32'(e_wb));
    chk("wb_result", bus.wb_result, e_res);
    chk("wb_rd_num", 32'(bus.wb_rd_num), 32'(e_rd));
    chk("wb_reg_write", 32'(bus.wb_reg_write), 32'(e_rw));
    chk("wb_is_fp", 32'(bus.wb_is_fp), 32'(e_isfp));
    chk("wb_fp_flags", 32'(bus.wb_fp_flags), 32'(e_flags));
    chk("fp_status", 32'(bus.fp_status), 32'(e_status));
`ifdef EX_SCHED_PERF_CNT_EN
    chk("perf_stall", bus.perf_stall_cycles, e_perf_stall);
    chk("perf_fp", bus.perf_fp_ops, e_perf_fp);
`else
    chk("perf_stall_tied", bus.perf_stall_cycles, 32'd0);
    chk("perf_fp_tied", bus.perf_fp_ops, 32'd0);
`endif
  endtask

  initial begin
    cyc = 0;
    reset = 1'b1;
    set_idle();
    model_reset();
    bus.issue_valid = 0; bus.issue_is_nop = 0; bus.issue_is_fp = 0; bus.issue_alu_op = '0;
    bus.issue_rd_num = '0; bus.issue_reg_write = 0; bus.flush = 0; bus.alu_result = '0;
    bus.falu_result = '0; bus.fp_flags = '0; bus.fp_status_clear = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_result", bus.wb_result, 32'd0);
    chk("rst_fp_status", 32'(bus.fp_status), 32'd0);
    reset = 1'b0;

    // integer op, one-cycle writeback
    set_op(0, 5'd0, 5'd8, 32'h0000_0005, 6'd0); step();
    set_idle(); step();

    // FP add: held in EX for its full latency
    set_op(1, 5'b00000, 5'd3, 32'h4040_0000, 6'b000001);
    repeat (LAT_FADD) step();
    set_idle(); step();
    chk("fadd_status", 32'(bus.fp_status), 32'h01);

    // FP div followed immediately by an integer op
    set_op(1, 5'b00011, 5'd12, 32'h3F80_0000, 6'b000010);
    repeat (LAT_FDIV) step();
    set_op(0, 5'd4, 5'd13, 32'h1234_5678, 6'd0); step();
    set_idle(); step();
    chk("div_int_result", bus.wb_result, 32'h1234_5678);

    // FP mul flushed in its third cycle, new op accepted next
    set_op(1, 5'b00010, 5'd5, 32'h4100_0000, 6'b001000);
    step(); step();
    d_flush = 1; step();
    set_op(0, 5'd1, 5'd6, 32'h0000_00AA, 6'd0); step();
    set_idle(); step();

    // clear coinciding with completion keeps only the new flags
    d_clr = 1; step();
    set_op(1, 5'b00001, 5'd7, 32'h1111_1111, 6'b000100);
    repeat (LAT_FADD) step();
    set_op(1, 5'b00000, 5'd9, 32'h2222_2222, 6'b100000);
    step(); step();
    d_clr = 1; step();
    chk("clr_at_done", 32'(bus.fp_status), 32'h20);
    set_idle(); step();

    for (int i = 0; i < 1500; i++) begin
      set_random(); step();
    end

    // reset in the middle of an FP div
    set_op(1, 5'b00011, 5'd2, 32'h5555_5555, 6'b010000);
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("midrst_fp_status", 32'(bus.fp_status), 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    set_idle(); step();

    for (int i = 0; i < 500; i++) begin
      set_random(); step();
    end
    set_idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
